regfile_mp: RTL and testbench
=============================

Name: regfile_mp

Overview:
- Parametrised integer register file for the RV32/RV64 core, replacing the single-write, unreset register array.
- Adds configurable width, depth and port counts, asynchronous reset, hardwired-zero x0, optional write-to-read bypass and a per-register busy scoreboard.
- Sits between decode (read and issue side) and writeback.

Parameters:
- XLEN, 32, data width in bits.
- NREGS, 32, number of architectural registers; a power of two, at least 2.
- NRD, 2, number of read ports.
- NWR, 1, number of write ports.
- BYPASS, 1, when 1 a same-cycle write is forwarded to a matching read port.
- AW, $clog2(NREGS), register address width; derived, never overridden.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- rd_addr  in  NRD*AW  read addresses; port i occupies bits [i*AW +: AW].
- rd_data  out  NRD*XLEN  read data, combinational.
- rd_busy  out  NRD  scoreboard busy bit of each read address.
- wr_en  in  NWR  write enables.
- wr_addr  in  NWR*AW  write addresses.
- wr_data  in  NWR*XLEN  write data.
- iss_valid  in  1  an instruction issues that will write register iss_rd.
- iss_rd  in  AW  destination register of the issuing instruction.
- wb_clr  in  NWR  clears the busy bit of wr_addr[j]; independent of wr_en[j].
- a0  out  XLEN  current value of register 10, registered contents only, no bypass; tied to 0 if NREGS is 10 or less.

Behaviour:
- Reset (rst_n low, asynchronous):
  - all registers are cleared to 0 and all busy bits are cleared;
  - the array is cleared through a reset branch, so it synthesises to flops;
  - rd_data reflects the zeroed array immediately;
  - deassertion is sampled at the next rising clk edge.
- Writes:
  - take effect at the rising clk edge, with non-blocking semantics, when wr_en[j] is high and wr_addr[j] is not 0;
  - writes to x0 are discarded.
- Write collision: if two ports write the same address in one cycle, the highest port index wins.
- Reads:
  - combinational; address 0 always returns 0;
  - with BYPASS=1, a read whose address matches an enabled, nonzero wr_addr[j] returns that port's wr_data, highest index winning;
  - with BYPASS=0, a read returns the registered value, and new data is visible one cycle after the write edge.
- Scoreboard, one busy bit per register with busy[0] permanently 0:
  - at each edge, clear busy[wr_addr[j]] for every j where wb_clr[j] is high;
  - then set busy[iss_rd] if iss_valid is high and iss_rd is not 0;
  - set wins over clear for the same register in the same cycle, because a new producer supersedes the retiring one;
  - issuing to a register that is already busy is legal and it stays busy;
  - clearing a register that is not busy has no effect.
- rd_busy[i] = busy[rd_addr[i]]; it is the registered value and is not bypassed by a same-cycle wb_clr.
- Latency: read 0 cycles; write 1 edge; busy set and clear 1 edge.
- Reset asserted mid-operation:
  - in-flight writes and issues in that cycle are lost;
  - the registers and scoreboard are cleared together.
- No X may propagate from uninitialised state, because reset covers all state.

Decomposition:
- Shared package rv_pkg holds:
  - XLEN_DEFAULT, NREGS_DEFAULT;
  - REG_ZERO = 0, REG_A0 = 10;
  - the typedef reg_addr_t.
- One sub-module, regfile_scoreboard, holds the busy-bit vector, the set/clear priority logic and the rd_busy lookup.
- The data array, write logic and bypass stay in regfile_mp.

Test Plan:
- Reset behaviour: hold rst_n low mid-run after writing x5 = 0xDEADBEEF → rd_data for x5 reads 0 asynchronously and all rd_busy are 0.
- x0 handling: write x0 = 0x12345678 with iss_valid, iss_rd = 0 → x0 reads 0 and rd_busy for x0 is 0.
- Bypass on/off:
  - BYPASS=1: write x7 = 0xA5A5A5A5 while reading x7 → the same cycle returns 0xA5A5A5A5;
  - BYPASS=0: the same stimulus returns the old value, and 0xA5A5A5A5 appears one cycle later.
- Write collision: NWR=2, both ports write x3 (0x1 on port 0, 0x2 on port 1) → x3 = 0x2, and a0 shows a write to x10 after the edge.
- Scoreboard priority:
  - issue x9 → busy the next cycle;
  - wb_clr x9 together with a new issue of x9 in the same cycle → still busy;
  - wb_clr alone → not busy.
- Parametrisation: XLEN=64, NREGS=16, NRD=3 → writing 0xFFFF_0000_FFFF_0000 to x15 is read back on all three ports, and a0 tracks x10.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared constants and types for the integer register file.
package rv_pkg;

  localparam int XLEN_DEFAULT  = 32;
  localparam int NREGS_DEFAULT = 32;
  localparam int REG_ZERO      = 0;
  localparam int REG_A0        = 10;

  typedef logic [$clog2(NREGS_DEFAULT)-1:0] reg_addr_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy scoreboard: set on issue, clear on writeback, set wins.
// busy[0] is never set because x0 has no producer to wait for.
module regfile_scoreboard
  import rv_pkg::*;
#(
  parameter int NREGS = NREGS_DEFAULT,
  parameter int NRD   = 2,
  parameter int NWR   = 1,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NRD*AW-1:0] rd_addr,
  output logic [NRD-1:0]    rd_busy,
  input  logic [NWR*AW-1:0] wr_addr,
  input  logic [NWR-1:0]    wb_clr,
  input  logic              iss_valid,
  input  logic [AW-1:0]     iss_rd
);

  localparam logic [NREGS-1:0] ONE_HOT0 = {{(NREGS-1){1'b0}}, 1'b1};

  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;
  logic [NREGS-1:0] clr_mask_s;
  logic [NREGS-1:0] set_mask_s;

  // Build clear/set masks; set is applied after clear so a new producer wins.
  always_comb begin
    clr_mask_s = {NREGS{1'b0}};
    for (int j = 0; j < NWR; j++) begin
      clr_mask_s = clr_mask_s | ({{(NREGS-1){1'b0}}, wb_clr[j]} << wr_addr[j*AW +: AW]);
    end
    set_mask_s = {{(NREGS-1){1'b0}}, iss_valid} << iss_rd;
    busy_d     = ((busy_q & ~clr_mask_s) | set_mask_s) & ~ONE_HOT0;
  end

  // Busy vector register, cleared by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= {NREGS{1'b0}};
    end else begin
      busy_q <= busy_d;
    end
  end

  // Registered busy lookup per read port (no same-cycle clear forwarding).
  for (genvar i = 0; i < NRD; i++) begin : g_rd_busy
    assign rd_busy[i] = busy_q[rd_addr[i*AW +: AW]];
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file with hardwired-zero x0, optional
// write-to-read bypass, reset-cleared array and a busy scoreboard.
module regfile_mp
  import rv_pkg::*;
#(
  parameter int XLEN   = XLEN_DEFAULT,
  parameter int NREGS  = NREGS_DEFAULT,
  parameter int NRD    = 2,
  parameter int NWR    = 1,
  parameter int BYPASS = 1,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic [NWR-1:0]      wr_en,
  input  logic [NWR*AW-1:0]   wr_addr,
  input  logic [NWR*XLEN-1:0] wr_data,
  input  logic                iss_valid,
  input  logic [AW-1:0]       iss_rd,
  input  logic [NWR-1:0]      wb_clr,
  output logic [XLEN-1:0]     a0
);

  localparam logic [AW-1:0] ADDR_ZERO = AW'(REG_ZERO);

  logic [XLEN-1:0] regs_q [NREGS];
  logic [XLEN-1:0] regs_d [NREGS];

  logic [AW-1:0]   rd_addr_s [NRD];
  logic [XLEN-1:0] rd_val_s  [NRD];
  logic [AW-1:0]   wr_addr_s [NWR];
  logic [XLEN-1:0] wr_data_s [NWR];

  for (genvar i = 0; i < NRD; i++) begin : g_rd_unpack
    assign rd_addr_s[i]               = rd_addr[i*AW +: AW];
    assign rd_data[i*XLEN +: XLEN]    = rd_val_s[i];
  end

  for (genvar j = 0; j < NWR; j++) begin : g_wr_unpack
    assign wr_addr_s[j] = wr_addr[j*AW +: AW];
    assign wr_data_s[j] = wr_data[j*XLEN +: XLEN];
  end

  // Next array state: later write ports override earlier ones; x0 stays zero.
  always_comb begin
    for (int r = 0; r < NREGS; r++) begin
      regs_d[r] = regs_q[r];
      for (int j = 0; j < NWR; j++) begin
        regs_d[r] = (wr_en[j] && (wr_addr_s[j] == AW'(r))) ? wr_data_s[j] : regs_d[r];
      end
    end
    regs_d[REG_ZERO] = {XLEN{1'b0}};
  end

  // Register array; reset branch clears every entry so it maps to flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREGS; r++) begin
        regs_q[r] <= {XLEN{1'b0}};
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  // Combinational read with optional same-cycle forwarding of pending writes.
  always_comb begin
    for (int i = 0; i < NRD; i++) begin
      rd_val_s[i] = regs_q[rd_addr_s[i]];
      for (int j = 0; j < NWR; j++) begin
        rd_val_s[i] = ((BYPASS != 0) && wr_en[j] && (wr_addr_s[j] != ADDR_ZERO) &&
                       (wr_addr_s[j] == rd_addr_s[i])) ? wr_data_s[j] : rd_val_s[i];
      end
      rd_val_s[i] = (rd_addr_s[i] == ADDR_ZERO) ? {XLEN{1'b0}} : rd_val_s[i];
    end
  end

  // a0 exposes the stored value of x10 only, never the bypass path.
  if (NREGS > REG_A0) begin : g_a0
    assign a0 = regs_q[REG_A0];
  end else begin : g_no_a0
    assign a0 = {XLEN{1'b0}};
  end

  regfile_scoreboard #(
    .NREGS (NREGS),
    .NRD   (NRD),
    .NWR   (NWR),
    .AW    (AW)
  ) u_scoreboard (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_addr   (rd_addr),
    .rd_busy   (rd_busy),
    .wr_addr   (wr_addr),
    .wb_clr    (wb_clr),
    .iss_valid (iss_valid),
    .iss_rd    (iss_rd)
  );

endmodule

// File: tb/tb_regfile_mp.sv
// Directed self-checking bench for regfile_mp. Three instances cover
// bypass on with two write ports, bypass off, and a 64-bit/16-entry/3-read build.
module tb_regfile_mp;

  logic clk;
  logic rst_n;

  // Instance A: XLEN=32, NREGS=32, NRD=2, NWR=2, BYPASS=1
  logic [9:0]  a_rd_addr;
  logic [63:0] a_rd_data;
  logic [1:0]  a_rd_busy;
  logic [1:0]  a_wr_en;
  logic [9:0]  a_wr_addr;
  logic [63:0] a_wr_data;
  logic        a_iss_valid;
  logic [4:0]  a_iss_rd;
  logic [1:0]  a_wb_clr;
  logic [31:0] a_a0;

  // Instance B: XLEN=32, NREGS=32, NRD=2, NWR=1, BYPASS=0
  logic [9:0]  b_rd_addr;
  logic [63:0] b_rd_data;
  logic [1:0]  b_rd_busy;
  logic [0:0]  b_wr_en;
  logic [4:0]  b_wr_addr;
  logic [31:0] b_wr_data;
  logic        b_iss_valid;
  logic [4:0]  b_iss_rd;
  logic [0:0]  b_wb_clr;
  logic [31:0] b_a0;

  // Instance C: XLEN=64, NREGS=16, NRD=3, NWR=1, BYPASS=1
  logic [11:0]  c_rd_addr;
  logic [191:0] c_rd_data;
  logic [2:0]   c_rd_busy;
  logic [0:0]   c_wr_en;
  logic [3:0]   c_wr_addr;
  logic [63:0]  c_wr_data;
  logic         c_iss_valid;
  logic [3:0]   c_iss_rd;
  logic [0:0]   c_wb_clr;
  logic [63:0]  c_a0;

  int n_assert;
  int n_fail;

  regfile_mp #(.XLEN(32), .NREGS(32), .NRD(2), .NWR(2), .BYPASS(1)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .rd_addr(a_rd_addr), .rd_data(a_rd_data),
    .rd_busy(a_rd_busy), .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data),
    .iss_valid(a_iss_valid), .iss_rd(a_iss_rd), .wb_clr(a_wb_clr), .a0(a_a0)
  );

  regfile_mp #(.XLEN(32), .NREGS(32), .NRD(2), .NWR(1), .BYPASS(0)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .rd_addr(b_rd_addr), .rd_data(b_rd_data),
    .rd_busy(b_rd_busy), .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
    .iss_valid(b_iss_valid), .iss_rd(b_iss_rd), .wb_clr(b_wb_clr), .a0(b_a0)
  );

  regfile_mp #(.XLEN(64), .NREGS(16), .NRD(3), .NWR(1), .BYPASS(1)) u_dut_c (
    .clk(clk), .rst_n(rst_n), .rd_addr(c_rd_addr), .rd_data(c_rd_data),
    .rd_busy(c_rd_busy), .wr_en(c_wr_en), .wr_addr(c_wr_addr), .wr_data(c_wr_data),
    .iss_valid(c_iss_valid), .iss_rd(c_iss_rd), .wb_clr(c_wb_clr), .a0(c_a0)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge, sampling 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    rst_n = 1'b0;
    a_rd_addr = 10'd0; a_wr_en = 2'b00; a_wr_addr = 10'd0; a_wr_data = 64'd0;
    a_iss_valid = 1'b0; a_iss_rd = 5'd0; a_wb_clr = 2'b00;
    b_rd_addr = 10'd0; b_wr_en = 1'b0; b_wr_addr = 5'd0; b_wr_data = 32'd0;
    b_iss_valid = 1'b0; b_iss_rd = 5'd0; b_wb_clr = 1'b0;
    c_rd_addr = 12'd0; c_wr_en = 1'b0; c_wr_addr = 4'd0; c_wr_data = 64'd0;
    c_iss_valid = 1'b0; c_iss_rd = 4'd0; c_wb_clr = 1'b0;

    // Reset state
    #1;
    a_rd_addr = {5'd10, 5'd5};
    #1;
    chk("reset_rd_data", a_rd_data, 192'd0);
    chk("reset_rd_busy", a_rd_busy, 192'd0);
    chk("reset_a0", a_a0, 192'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Write x5 = DEADBEEF and issue x5, then reset asynchronously mid-run
    a_wr_en = 2'b01; a_wr_addr = {5'd0, 5'd5}; a_wr_data = {32'd0, 32'hDEADBEEF};
    a_iss_valid = 1'b1; a_iss_rd = 5'd5;
    tick();
    a_wr_en = 2'b00; a_iss_valid = 1'b0;
    a_rd_addr = {5'd0, 5'd5};
    #1;
    chk("x5_written", a_rd_data[31:0], 192'hDEADBEEF);
    chk("x5_busy", a_rd_busy[0], 192'd1);
    rst_n = 1'b0;
    #1;
    chk("x5_async_reset", a_rd_data[31:0], 192'd0);
    chk("busy_async_reset", a_rd_busy, 192'd0);
    #1;
    rst_n = 1'b1;
    tick();

    // x0: writes and issues to x0 are discarded
    a_wr_en = 2'b01; a_wr_addr = {5'd0, 5'd0}; a_wr_data = {32'd0, 32'h12345678};
    a_iss_valid = 1'b1; a_iss_rd = 5'd0;
    a_rd_addr = {5'd0, 5'd0};
    #1;
    chk("x0_no_bypass", a_rd_data[31:0], 192'd0);
    tick();
    a_wr_en = 2'b00; a_iss_valid = 1'b0;
    #1;
    chk("x0_reads_zero", a_rd_data[31:0], 192'd0);
    chk("x0_not_busy", a_rd_busy[0], 192'd0);

    // Bypass on (A) versus off (B) for x7
    a_wr_en = 2'b01; a_wr_addr = {5'd0, 5'd7}; a_wr_data = {32'd0, 32'hA5A5A5A5};
    a_rd_addr = {5'd7, 5'd0};
    b_wr_en = 1'b1; b_wr_addr = 5'd7; b_wr_data = 32'hA5A5A5A5;
    b_rd_addr = {5'd0, 5'd7};
    #1;
    chk("bypass_on_same_cycle", a_rd_data[63:32], 192'hA5A5A5A5);
    chk("bypass_off_old_value", b_rd_data[31:0], 192'd0);
    tick();
    a_wr_en = 2'b00; b_wr_en = 1'b0;
    #1;
    chk("bypass_on_after_edge", a_rd_data[63:32], 192'hA5A5A5A5);
    chk("bypass_off_after_edge", b_rd_data[31:0], 192'hA5A5A5A5);

    // Write collision on x3: port 1 wins, both for bypass and for storage
    a_wr_en = 2'b11; a_wr_addr = {5'd3, 5'd3}; a_wr_data = {32'h2, 32'h1};
    a_rd_addr = {5'd0, 5'd3};
    #1;
    chk("collision_bypass", a_rd_data[31:0], 192'h2);
    tick();
    a_wr_en = 2'b00;
    #1;
    chk("collision_stored", a_rd_data[31:0], 192'h2);

    // a0 shows x10 only after the write edge
    a_wr_en = 2'b01; a_wr_addr = {5'd0, 5'd10}; a_wr_data = {32'd0, 32'hCAFEF00D};
    #1;
    chk("a0_before_edge", a_a0, 192'd0);
    tick();
    a_wr_en = 2'b00;
    #1;
    chk("a0_after_edge", a_a0, 192'hCAFEF00D);

    // Scoreboard: issue, clear+issue same cycle, clear alone
    a_rd_addr = {5'd0, 5'd9};
    a_iss_valid = 1'b1; a_iss_rd = 5'd9;
    #1;
    chk("sb_not_busy_before", a_rd_busy[0], 192'd0);
    tick();
    chk("sb_busy_after_issue", a_rd_busy[0], 192'd1);
    a_wb_clr = 2'b01; a_wr_addr = {5'd0, 5'd9};
    tick();
    chk("sb_set_beats_clear", a_rd_busy[0], 192'd1);
    a_iss_valid = 1'b0;
    #1;
    chk("sb_clear_not_bypassed", a_rd_busy[0], 192'd1);
    tick();
    a_wb_clr = 2'b00;
    #1;
    chk("sb_cleared", a_rd_busy[0], 192'd0);

    // Clear through write port 1, and clearing an idle register is harmless
    a_iss_valid = 1'b1; a_iss_rd = 5'd12; a_rd_addr = {5'd12, 5'd9};
    tick();
    a_iss_valid = 1'b0;
    chk("sb_x12_busy", a_rd_busy, 192'b10);
    a_wb_clr = 2'b11; a_wr_addr = {5'd12, 5'd9};
    tick();
    a_wb_clr = 2'b00;
    chk("sb_port1_clear", a_rd_busy, 192'b00);

    // 64-bit, 16-entry, 3 read ports
    c_wr_en = 1'b1; c_wr_addr = 4'd15; c_wr_data = 64'hFFFF_0000_FFFF_0000;
    c_rd_addr = {4'd15, 4'd15, 4'd15};
    #1;
    chk("c_bypass_3ports", c_rd_data,
        {64'hFFFF_0000_FFFF_0000, 64'hFFFF_0000_FFFF_0000, 64'hFFFF_0000_FFFF_0000});
    tick();
    c_wr_en = 1'b0;
    #1;
    chk("c_stored_3ports", c_rd_data,
        {64'hFFFF_0000_FFFF_0000, 64'hFFFF_0000_FFFF_0000, 64'hFFFF_0000_FFFF_0000});
    c_wr_en = 1'b1; c_wr_addr = 4'd10; c_wr_data = 64'h0123_4567_89AB_CDEF;
    tick();
    c_wr_en = 1'b0;
    #1;
    chk("c_a0_tracks_x10", c_a0, 192'h0123_4567_89AB_CDEF);
    c_rd_addr = {4'd0, 4'd10, 4'd15};
    #1;
    chk("c_mixed_reads", c_rd_data,
        {64'd0, 64'h0123_4567_89AB_CDEF, 64'hFFFF_0000_FFFF_0000});

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
